// File: rtl/avr_seq_pkg.sv
// ----------------------------------------------------------------------------
// avr_seq_pkg
// Shared definitions for the register-file write sequencer:
//   - rf_cls_e     : write-timing class of an instruction word
//   - St*          : sequencer FSM state encodings
//   - Op*          : full-word opcodes that need an exact match
//   - *_nib_class  : low-nibble tables of the 1001_00xx load/store group
// ----------------------------------------------------------------------------
package avr_seq_pkg;

    typedef enum logic [2:0] {
        ClsNone  = 3'd0,
        ClsAlu1  = 3'd1,
        ClsWr2   = 3'd2,
        ClsSt2   = 3'd3,
        ClsStPtr = 3'd4,
        ClsLd    = 3'd5,
        ClsLdPtr = 3'd6
    } rf_cls_e;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    localparam logic [15:0] OpLpmR0 = 16'h95C8;  // LPM (R0 implied)
    localparam logic [15:0] OpSpm   = 16'h95E8;

    // 1001_000d_dddd_nnnn: LDS, LD/LDD forms, LPM Rd,Z(+), POP
    function automatic rf_cls_e ld_nib_class(input logic [3:0] nib);
        case (nib)
            4'h0, 4'h4, 4'hC, 4'hF:                    return ClsLd;
            4'h1, 4'h2, 4'h5, 4'h9, 4'hA, 4'hD, 4'hE:  return ClsLdPtr;
            default:                                   return ClsNone;
        endcase
    endfunction

    // 1001_001r_rrrr_nnnn: STS, ST forms, PUSH
    function automatic rf_cls_e st_nib_class(input logic [3:0] nib);
        case (nib)
            4'h0, 4'hC, 4'hF:                    return ClsSt2;
            4'h1, 4'h2, 4'h9, 4'hA, 4'hD, 4'hE:  return ClsStPtr;
            default:                             return ClsNone;
        endcase
    endfunction

    // 1001_010d_dddd_nnnn: COM/NEG/SWAP/INC/ASR/LSR/ROR/DEC
    function automatic logic alu_nib(input logic [3:0] nib);
        case (nib)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'hA: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rf_wr_classify.sv
// ----------------------------------------------------------------------------
// rf_wr_classify
// Purely combinational decode of an AVR instruction word into its
// register-file write-timing class.
//   i_ir  : instruction word
//   o_cls : write-timing class (ClsNone for branches, compares, undefined)
// ----------------------------------------------------------------------------
module rf_wr_classify
    import avr_seq_pkg::*;
(
    input  logic [15:0] i_ir,
    output rf_cls_e     o_cls
);

    always_comb begin
        o_cls = ClsNone;
        case (i_ir[15:12])
            4'h0: begin
                casez (i_ir[11:8])
                    4'b0001: o_cls = ClsAlu1;  // MOVW
                    4'b001?: o_cls = ClsWr2;   // MULS, MULSU, FMUL*
                    4'b1???: o_cls = ClsAlu1;  // SBC, ADD
                    default: o_cls = ClsNone;  // NOP, CPC
                endcase
            end
            4'h1:       o_cls = i_ir[11] ? ClsAlu1 : ClsNone;  // SUB/ADC vs CPSE/CP
            4'h2,
            4'h4, 4'h5,
            4'h6, 4'h7,
            4'hE:       o_cls = ClsAlu1;
            // LDD/STD with displacement (LD/ST Y, Z without increment included)
            4'h8, 4'hA: o_cls = i_ir[9] ? ClsSt2 : ClsLd;
            4'h9: begin
                case (i_ir[11:9])
                    3'b000: o_cls = ld_nib_class(i_ir[3:0]);
                    3'b001: o_cls = st_nib_class(i_ir[3:0]);
                    3'b010: begin
                        if (i_ir == OpLpmR0) begin
                            o_cls = ClsLd;
                        end else if (i_ir == OpSpm) begin
                            o_cls = ClsSt2;
                        end else if (alu_nib(i_ir[3:0])) begin
                            o_cls = ClsAlu1;
                        end
                    end
                    3'b011:         o_cls = ClsWr2;  // ADIW, SBIW
                    3'b110, 3'b111: o_cls = ClsWr2;  // MUL
                    default:        o_cls = ClsNone; // CBI/SBI/SBIC/SBIS
                endcase
            end
            4'hB:       o_cls = i_ir[11] ? ClsSt2 : ClsLd;  // OUT vs IN
            4'hF: begin
                // BLD only; BST, SBRC/SBRS and branches do not write
                if (i_ir[11:9] == 3'b100 && !i_ir[3]) begin
                    o_cls = ClsAlu1;
                end
            end
            default:    o_cls = ClsNone;
        endcase
    end

endmodule

// File: rtl/rf_write_seq.sv
// ----------------------------------------------------------------------------
// rf_write_seq
// Register-file write sequencer: classifies each accepted instruction and
// steps it through its execution cycles, producing the cycle index and the
// register-file write strobe; loads wait for memory/program-memory data.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_ir             : instruction word (held by fetch while o_busy)
//   i_inst_valid     : i_ir holds a new instruction
//   o_inst_ready     : instruction accepted this cycle when valid
//   i_stall          : global freeze
//   i_flush          : abort current instruction
//   i_mm_rdata_en    : data-memory read data valid
//   i_lpm_data_en    : program-memory load data valid
//   o_cycle          : execution cycle index
//   o_tim_rf_we      : register-file write timing strobe
//   o_inst_done      : last cycle of current instruction
//   o_busy           : multi-cycle instruction in progress
//   o_wait_err       : one-cycle pulse when a load times out
// WAIT_MAX (1..255): data-wait cycles before a load is aborted.
// ----------------------------------------------------------------------------
module rf_write_seq
    import avr_seq_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_ir,
    input  logic        i_inst_valid,
    output logic        o_inst_ready,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_mm_rdata_en,
    input  logic        i_lpm_data_en,
    output logic [1:0]  o_cycle,
    output logic        o_tim_rf_we,
    output logic        o_inst_done,
    output logic        o_busy,
    output logic        o_wait_err
);

    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    logic [1:0] r_state, w_state_d;
    logic [1:0] r_cnt,   w_cnt_d;
    logic [7:0] r_wcnt,  w_wcnt_d;
    rf_cls_e    r_cls,   w_cls_d;
    rf_cls_e    w_cls;
    logic       w_data_en;

    rf_wr_classify u_classify (
        .i_ir  (i_ir),
        .o_cls (w_cls)
    );

    assign w_data_en    = i_mm_rdata_en | i_lpm_data_en;
    assign o_inst_ready = (r_state == StIdle) & ~i_stall;
    assign o_busy       = (r_state != StIdle);
    // cnt is 0 in IDLE and 1 in RUN/WAIT, so it is the cycle index directly
    assign o_cycle      = r_cnt;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_wcnt_d    = r_wcnt;
        w_cls_d     = r_cls;
        o_tim_rf_we = 1'b0;
        o_inst_done = 1'b0;
        o_wait_err  = 1'b0;

        if (i_flush) begin
            w_state_d = StIdle;
            w_cnt_d   = 2'd0;
            w_wcnt_d  = 8'd0;
        end else if (!i_stall) begin
            case (r_state)
                StIdle: begin
                    if (i_inst_valid) begin
                        w_cls_d     = w_cls;
                        o_tim_rf_we = (w_cls == ClsAlu1) || (w_cls == ClsStPtr) ||
                                      (w_cls == ClsLdPtr);
                        case (w_cls)
                            ClsWr2, ClsSt2, ClsStPtr: begin
                                w_state_d = StRun;
                                w_cnt_d   = 2'd1;
                            end
                            ClsLd, ClsLdPtr: begin
                                w_state_d = StWait;
                                w_cnt_d   = 2'd1;
                                w_wcnt_d  = 8'd0;
                            end
                            default: o_inst_done = 1'b1;
                        endcase
                    end
                end
                StRun: begin
                    o_tim_rf_we = (r_cls == ClsWr2);
                    o_inst_done = 1'b1;
                    w_state_d   = StIdle;
                    w_cnt_d     = 2'd0;
                end
                StWait: begin
                    // data arriving on the timeout cycle still wins
                    if (w_data_en) begin
                        o_tim_rf_we = 1'b1;
                        o_inst_done = 1'b1;
                        w_state_d   = StIdle;
                        w_cnt_d     = 2'd0;
                        w_wcnt_d    = 8'd0;
                    end else if (r_wcnt == WaitLast) begin
                        o_wait_err = 1'b1;
                        w_state_d  = StIdle;
                        w_cnt_d    = 2'd0;
                        w_wcnt_d   = 8'd0;
                    end else begin
                        w_wcnt_d = r_wcnt + 8'd1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = 2'd0;
                    w_wcnt_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 2'd0;
            r_wcnt  <= 8'd0;
            r_cls   <= ClsNone;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_wcnt  <= w_wcnt_d;
            r_cls   <= w_cls_d;
        end
    end

endmodule

// File: tb/tb_rf_write_seq.sv
// ----------------------------------------------------------------------------
// tb_rf_write_seq
// Directed stimulus; each expected output event (write/done/error) is queued
// with the clock tick it must appear on, and a monitor pops and compares
// whenever the DUT presents one.
// ----------------------------------------------------------------------------
module tb_rf_write_seq;

    localparam int unsigned WaitMax = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mm_rdata_en = 1'b0;
    logic        lpm_data_en = 1'b0;
    logic [1:0]  cycle;
    logic        tim_rf_we;
    logic        inst_done;
    logic        busy;
    logic        wait_err;

    rf_write_seq #(
        .WAIT_MAX (WaitMax)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ir          (ir),
        .i_inst_valid  (inst_valid),
        .o_inst_ready  (inst_ready),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_mm_rdata_en (mm_rdata_en),
        .i_lpm_data_en (lpm_data_en),
        .o_cycle       (cycle),
        .o_tim_rf_we   (tim_rf_we),
        .o_inst_done   (inst_done),
        .o_busy        (busy),
        .o_wait_err    (wait_err)
    );

    always #5 clk = ~clk;

    int unsigned tick = 0;
    always @(posedge clk) tick <= tick + 1;

    typedef struct {
        int unsigned t;
        logic [1:0]  cyc;
        logic        we;
        logic        done;
        logic        err;
        logic        bsy;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    function automatic void expect_ev(input int unsigned t, input logic [1:0] cyc,
                                      input logic we, input logic done, input logic err,
                                      input logic bsy);
        ev_t e;
        e.t = t; e.cyc = cyc; e.we = we; e.done = done; e.err = err; e.bsy = bsy;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst_n && (tim_rf_we || inst_done || wait_err)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event tick=%0d got cyc=%0d we=%0b done=%0b err=%0b, required no event",
                         tick, cycle, tim_rf_we, inst_done, wait_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.t != tick || mon_e.cyc != cycle || mon_e.we != tim_rf_we ||
                    mon_e.done != inst_done || mon_e.err != wait_err || mon_e.bsy != busy) begin
                    n_bad++;
                    $display("FAIL event got tick=%0d cyc=%0d we=%0b done=%0b err=%0b busy=%0b, required tick=%0d cyc=%0d we=%0b done=%0b err=%0b busy=%0b",
                             tick, cycle, tim_rf_we, inst_done, wait_err, busy,
                             mon_e.t, mon_e.cyc, mon_e.we, mon_e.done, mon_e.err, mon_e.bsy);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cycle"}, int'(cycle), 0);
        chk({tag, "_we"}, int'(tim_rf_we), 0);
        chk({tag, "_done"}, int'(inst_done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(wait_err), 0);
        chk({tag, "_ready"}, int'(inst_ready), 1);
    endtask

    // single-cycle instructions: ADD LDI MOVW INC CP NOP BLD BST
    logic [15:0] one_ir [8] = '{16'h0C12, 16'hEF0F, 16'h0112, 16'h9403,
                                16'h1412, 16'h0000, 16'hF800, 16'hFA00};
    logic [7:0]  one_we = 8'b0100_1111;
    // two-cycle instructions: MUL ADIW MULS PUSH OUT ST Y
    logic [15:0] two_ir [6] = '{16'h9C34, 16'h9601, 16'h0212, 16'h920F,
                                16'hB800, 16'h8208};
    logic [5:0]  two_we = 6'b00_0111;

    initial begin
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // back-to-back single-cycle instructions, one per clock
        for (int i = 0; i < 8; i++) begin
            ir = one_ir[i];
            inst_valid = 1'b1;
            expect_ev(tick, 2'd0, one_we[i], 1'b1, 1'b0, 1'b0);
            step(1);
        end
        inst_valid = 1'b0;
        step(1);

        // two-cycle instructions; next accept lands in the cycle after done
        for (int i = 0; i < 6; i++) begin
            ir = two_ir[i];
            inst_valid = 1'b1;
            #2;
            chk("two_c0_busy", int'(busy), 0);
            step(1);
            inst_valid = 1'b0;
            expect_ev(tick, 2'd1, two_we[i], 1'b1, 1'b0, 1'b1);
            #2;
            chk("two_c1_ready", int'(inst_ready), 0);
            step(1);
        end
        ir = 16'h0C12;
        inst_valid = 1'b1;
        expect_ev(tick, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        inst_valid = 1'b0;
        step(1);

        // LD R5,X+ : pointer write, data on the 3rd WAIT cycle
        ir = 16'h905D;
        inst_valid = 1'b1;
        expect_ev(tick, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        inst_valid = 1'b0;
        #2;
        chk("ldx_w1_cycle", int'(cycle), 1);
        step(1);
        #2;
        chk("ldx_w2_cycle", int'(cycle), 1);
        step(1);
        mm_rdata_en = 1'b1;
        expect_ev(tick, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1);
        mm_rdata_en = 1'b0;
        #2;
        chk("ldx_after_busy", int'(busy), 0);
        step(1);

        // ST X+,R7 with two stalled RUN cycles
        ir = 16'h927D;
        inst_valid = 1'b1;
        expect_ev(tick, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        inst_valid = 1'b0;
        stall = 1'b1;
        #2;
        chk("stx_stall_busy", int'(busy), 1);
        step(2);
        stall = 1'b0;
        expect_ev(tick, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(2);

        // LD R16,X with no data: timeout 15 cycles after cycle 0
        ir = 16'h910C;
        inst_valid = 1'b1;
        step(1);
        inst_valid = 1'b0;
        step(WaitMax - 1);
        expect_ev(tick, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1);
        #2;
        chk("timeout_busy", int'(busy), 0);
        step(1);

        // data on the timeout cycle wins
        ir = 16'h910C;
        inst_valid = 1'b1;
        step(1);
        inst_valid = 1'b0;
        step(WaitMax - 1);
        mm_rdata_en = 1'b1;
        expect_ev(tick, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1);
        mm_rdata_en = 1'b0;
        step(1);

        // LPM Rd,Z+ with minimum latency, then LPM R0
        ir = 16'h9005;
        inst_valid = 1'b1;
        expect_ev(tick, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        inst_valid = 1'b0;
        lpm_data_en = 1'b1;
        expect_ev(tick, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1);
        lpm_data_en = 1'b0;
        ir = 16'h95C8;
        inst_valid = 1'b1;
        step(1);
        inst_valid = 1'b0;
        lpm_data_en = 1'b1;
        expect_ev(tick, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1);
        lpm_data_en = 1'b0;
        step(1);

        // stalled WAIT ignores data; data held until stall drops
        ir = 16'h910C;
        inst_valid = 1'b1;
        step(1);
        inst_valid = 1'b0;
        stall = 1'b1;
        mm_rdata_en = 1'b1;
        step(1);
        stall = 1'b0;
        expect_ev(tick, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1);
        mm_rdata_en = 1'b0;
        step(1);

        // stall in IDLE blocks accept
        ir = 16'h0C12;
        inst_valid = 1'b1;
        stall = 1'b1;
        #2;
        chk("idle_stall_ready", int'(inst_ready), 0);
        step(1);
        stall = 1'b0;
        expect_ev(tick, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        inst_valid = 1'b0;

        // flush in WAIT beats data; flush in IDLE blocks accept
        ir = 16'h910C;
        inst_valid = 1'b1;
        step(1);
        inst_valid = 1'b0;
        flush = 1'b1;
        mm_rdata_en = 1'b1;
        step(1);
        flush = 1'b0;
        mm_rdata_en = 1'b0;
        #2;
        chk("flush_busy", int'(busy), 0);
        chk("flush_ready", int'(inst_ready), 1);
        step(1);
        ir = 16'h0C12;
        inst_valid = 1'b1;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        inst_valid = 1'b0;
        step(1);

        // asynchronous reset during MUL cycle 1
        ir = 16'h9C34;
        inst_valid = 1'b1;
        step(1);
        inst_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(3);

        chk("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
